// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide unit feeding the HI/LO register file.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whi_o,
  output logic        wlo_o,
  output logic        dz_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_dz;
  logic [31:0] r_hi, r_lo;
  logic        r_div, r_neg_q, r_neg_r;
  logic [31:0] r_m;
  logic [63:0] r_acc;

  logic        w_accept, w_dz_req;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix, w_rem_fix;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_dz_req = op_i[1] && (b_i == 32'd0);
  assign w_a_neg  = !op_i[0] && a_i[31];
  assign w_b_neg  = !op_i[0] && b_i[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - a_i) : a_i;
  assign w_b_mag  = w_b_neg ? (32'd0 - b_i) : b_i;

  // Multiply step: conditional add into the high half, then shift the whole accumulator right
  assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
  assign w_mul_next = {w_sum, r_acc[31:1]};

  // Divide step: remainder shifted left is below 2*divisor, so the 32-bit difference never wraps
  assign w_rem_sh   = r_acc[63:31];
  assign w_ge       = (w_rem_sh >= {1'b0, r_m});
  assign w_sub      = w_rem_sh[31:0] - r_m;
  assign w_div_next = w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

  assign w_prod_fix = r_neg_q ? (64'd0 - r_acc) : r_acc;
  assign w_quo_fix  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem_fix  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_dz_req ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush_i)             w_next = S_IDLE;
        else if (r_cnt == 5'd31) w_next = S_FIX;
      end
      S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_dz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= 5'd0;
        r_dz  <= w_dz_req;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (r_state == S_FIX && !flush_i) begin
        r_hi <= r_div ? w_rem_fix : w_prod_fix[63:32];
        r_lo <= r_div ? w_quo_fix : w_prod_fix[31:0];
      end
    end
  end

  // Operand/accumulator datapath carries no reset; control qualifies every use
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_div   <= op_i[1];
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_m     <= w_b_mag;
      r_acc   <= {32'd0, w_a_mag};
    end else if (r_state == S_CALC) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
    end
  end

  assign busy_o = (r_state != S_IDLE);
  assign done_o = (r_state == S_DONE);
  assign whi_o  = done_o && !r_dz;
  assign wlo_o  = done_o && !r_dz;
  assign dz_o   = done_o && r_dz;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed table, multi-cycle corner sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, whi, wlo, dz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;
  vec_t tbl[13];

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo),
    .whi_o(whi), .wlo_o(wlo), .dz_o(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    logic [63:0] p;
    longint sx, sy, q, r;
    rdz = 1'b0;
    rhi = m_hi;
    rlo = m_lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; rhi = p[63:32]; rlo = p[31:0]; end
      2'b10: begin
        if (y == 32'd0) rdz = 1'b1;
        else begin q = sx / sy; r = sx % sy; rlo = q[31:0]; rhi = r[31:0]; end
      end
      default: begin
        if (y == 32'd0) rdz = 1'b1;
        else begin rlo = x / y; rhi = x % y; end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input bit hold, input string nm);
    int cyc;
    int lat;
    bit busy_ok;
    lat = edz ? 1 : 34;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 60) begin
      if (!busy) busy_ok = 1'b0;
      if (hold) begin a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(cyc), 64'(lat));
    chk({nm, " busy"}, {63'd0, busy_ok & busy}, 64'd1);
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, elo});
    chk({nm, " flags done/whi/wlo/dz"}, {60'd0, done, whi, wlo, dz}, {60'd0, 1'b1, !edz, !edz, edz});
    @(posedge clk); #1;
    chk({nm, " after done/busy/whi/wlo"}, {60'd0, done, busy, whi, wlo}, 64'd0);
    if (!edz) begin m_hi = ehi; m_lo = elo; end
  endtask

  task automatic watch_quiet(input string nm, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || whi || wlo || busy) pulses++;
    end
    chk({nm, " quiet"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    logic [31:0] ehi, elo;
    logic        edz;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[4]  = '{2'b11, 32'h12345678, 32'd0,        32'h00000000, 32'h80000000, 1'b1};
    tbl[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[6]  = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
    tbl[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[10] = '{2'b10, 32'd5,        32'd0,        32'h40000000, 32'h00000000, 1'b1};
    tbl[11] = '{2'b01, 32'd0,        32'h00012345, 32'd0,        32'd0,        1'b0};
    tbl[12] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("reset outputs", {27'd0, busy, done, whi, wlo, dz, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);

    // First start accepted on the first edge after reset release
    repeat (2) @(negedge clk);
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start after reset busy", {63'd0, busy}, 64'd1);
    begin
      int cyc;
      cyc = 1;
      while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
      chk("post-reset op latency", 64'(cyc), 64'd34);
      chk("post-reset op result", {hi, lo}, {32'd0, 32'd42});
      m_hi = 32'd0; m_lo = 32'd42;
      @(posedge clk); #1;
    end

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, 1'b0, $sformatf("vec%0d", i));

    // Flush during CALC
    @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush calc busy", {63'd0, busy}, 64'd0);
    watch_quiet("flush calc", 40);
    chk("flush calc hold", {hi, lo}, {m_hi, m_lo});
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "divu after flush");

    // Flush during FIX
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("fix cycle busy/done", {62'd0, busy, done}, 64'd2);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush fix busy", {63'd0, busy}, 64'd0);
    watch_quiet("flush fix", 40);
    chk("flush fix hold", {hi, lo}, {32'd2, 32'd14});

    // Flush arriving in DONE does not cancel the pulse
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush in done pulse", {60'd0, done, whi, wlo, dz}, {60'd0, 4'b1110});
    chk("flush in done result", {hi, lo}, {32'd0, 32'd15});
    @(posedge clk); #1; flush = 1'b0;
    chk("flush in done idle", {63'd0, busy}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd15;

    // start with flush in IDLE does nothing
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("start+flush idle", {63'd0, busy}, 64'd0);

    // Reset mid-operation with start held high
    @(negedge clk);
    op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    #1;
    chk("calc20 busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid-op reset outputs", {27'd0, busy, done, whi, wlo, dz, hi}, 64'd0);
    chk("mid-op reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b0;
    watch_quiet("after reset", 40);
    m_hi = 32'd0; m_lo = 32'd0;

    // Operands must not be re-sampled while busy
    run_op(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].hi, tbl[0].lo, 1'b0, 1'b1, "hold start");

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        3: ra = 32'h80000000;
        default: ;
      endcase
      model(ro, ra, rb, ehi, elo, edz);
      run_op(ro, ra, rb, ehi, elo, edz, 1'b0, $sformatf("rand%0d op%0d", i, ro));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
